// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern and shifts it out MSB-first on x,
// one bit per enabled tick, with optional back-to-back repeats. Optional feature: PARITY_EN.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             x,
  output logic             frame,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request taken only on an enabled edge while idle; busy is the
  // acknowledgement, high from acceptance through the last bit; done pulses once at the end.

`ifdef PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int BCW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // shreg holds the bits still to be sent after the one currently on x
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic             x_q, x_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  logic last_bit;
  assign last_bit = (bitcnt_q == BCW'(FRAME_LEN - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      pat_q    <= '0;
      reps_q   <= '0;
      bitcnt_q <= '0;
      x_q      <= 1'b0;
      frame_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      pat_q    <= pat_d;
      reps_q   <= reps_d;
      bitcnt_q <= bitcnt_d;
      x_q      <= x_d;
      frame_q  <= frame_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Next-state logic; DONE always exits on the next clk edge, independent of clk_en
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clk_en && start) state_d = S_SHIFT;
      S_SHIFT: if (clk_en && last_bit && (reps_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next datapath values
  always_comb begin
    shreg_d  = shreg_q;
    pat_d    = pat_q;
    reps_d   = reps_q;
    bitcnt_d = bitcnt_q;
    x_d      = x_q;
    frame_d  = frame_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (clk_en && start) begin
          shreg_d  = pattern[WIDTH-2:0];
          pat_d    = pattern;
          reps_d   = repeat_cnt;
          bitcnt_d = '0;
          x_d      = pattern[WIDTH-1];
          frame_d  = 1'b1;
          busy_d   = 1'b1;
`ifdef PARITY_EN
          par_d    = ^pattern;
`endif
        end
      end
      S_SHIFT: begin
        if (clk_en) begin
          if (last_bit) begin
            if (reps_q != '0) begin
              // Next frame follows with no gap, from the latched copy
              shreg_d  = pat_q[WIDTH-2:0];
              reps_d   = reps_q - 1'b1;
              bitcnt_d = '0;
              x_d      = pat_q[WIDTH-1];
            end else begin
              x_d      = 1'b0;
              frame_d  = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            shreg_d  = shreg_q << 1;
            x_d      = shreg_q[WIDTH-2];
`ifdef PARITY_EN
            if (bitcnt_q == BCW'(WIDTH - 1)) x_d = par_q;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    x         = x_q;
    frame     = frame_q;
    busy      = busy_q;
    done      = done_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: vector table of transmissions plus hand-written
// sequences for clk_en gating, held start and mid-frame reset. Honors PARITY_EN when defined.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clk_en = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic             x, frame, busy, done;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];

  serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .pattern(pattern), .repeat_cnt(repeat_cnt),
    .x(x), .frame(frame), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pat;
    logic [CNT_W-1:0] rc;
    int               en_div;
    logic             hold_start;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference bit idx of a frame: data bits MSB-first, then the even-parity bit
  function automatic logic exp_bit(input logic [WIDTH-1:0] pat, input int idx);
    if (idx < WIDTH) return pat[WIDTH-1-idx];
    return ^pat;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || dbg_state != 2'd0) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic run_tx(input vec_t v, input string name);
    int cyc, busy_cyc, frame_cyc, exp_len;
    logic got_done;
    exp_q.delete();
    for (int r = 0; r <= int'(v.rc); r++)
      for (int i = 0; i < FLEN; i++)
        for (int k = 0; k < v.en_div; k++)
          exp_q.push_back(exp_bit(v.pat, i));
    exp_len = exp_q.size();
    pattern = v.pat; repeat_cnt = v.rc; start = 1'b1; clk_en = 1'b1;
    tick();
    // Alter inputs after acceptance; the latched copies must be used
    start = v.hold_start; pattern = ~v.pat; repeat_cnt = ~v.rc;
    cyc = 0; busy_cyc = 0; frame_cyc = 0; got_done = 1'b0;
    while (cyc < 600 && !got_done) begin
      if (frame) begin
        frame_cyc++;
        if (exp_q.size() == 0) chk({name, "_extra_bit"}, 32'd1, 32'd0);
        else chk({name, "_x"}, 32'(x), 32'(exp_q.pop_front()));
      end
      if (busy) busy_cyc++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        clk_en = (((cyc + 1) % v.en_div) == 0);
        tick();
        cyc++;
      end
    end
    chk({name, "_done_seen"}, 32'(got_done), 32'd1);
    chk({name, "_done_frame"}, {30'd0, frame, x}, 32'd0);
    chk({name, "_bits_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_len));
    chk({name, "_frame_cycles"}, 32'(frame_cyc), 32'(exp_len));
    start = 1'b0; clk_en = 1'b0;
    tick();
    chk({name, "_done_width"}, 32'(done), 32'd0);
    chk({name, "_back_idle"}, 32'(dbg_state), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{pat: 8'hA5, rc: 4'd0, en_div: 1, hold_start: 1'b0};
    vecs[1] = '{pat: 8'hF0, rc: 4'd2, en_div: 1, hold_start: 1'b0};
    vecs[2] = '{pat: 8'hA5, rc: 4'd0, en_div: 3, hold_start: 1'b0};
    vecs[3] = '{pat: 8'hA5, rc: 4'd0, en_div: 1, hold_start: 1'b1};
    vecs[4] = '{pat: 8'h07, rc: 4'd0, en_div: 1, hold_start: 1'b0};
    vecs[5] = '{pat: 8'h03, rc: 4'd1, en_div: 2, hold_start: 1'b0};
    vecs[6] = '{pat: 8'h81, rc: 4'd0, en_div: 1, hold_start: 1'b0};

    // Reset state
    reset = 1'b0;
    repeat (2) tick();
    chk("reset_outputs", {28'd0, x, frame, busy, done}, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    tick();

    // start is ignored on edges without clk_en
    pattern = 8'hFF; start = 1'b1; clk_en = 1'b0;
    repeat (3) tick();
    chk("gated_start_busy", 32'(busy), 32'd0);
    chk("gated_start_frame", 32'(frame), 32'd0);
    start = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_tx(vecs[i], $sformatf("vec%0d", i));

    // Start held high continuously: one DONE plus one IDLE cycle between frames
    pattern = 8'hA5; repeat_cnt = '0; start = 1'b1; clk_en = 1'b1;
    tick();
    for (int c = 0; c < 2 * (FLEN + 2); c++) begin
      int ph;
      ph = c % (FLEN + 2);
      chk("held_frame", 32'(frame), 32'(ph < FLEN));
      chk("held_done", 32'(done), 32'(ph == FLEN));
      chk("held_x", 32'(x), (ph < FLEN) ? 32'(exp_bit(8'hA5, ph)) : 32'd0);
      tick();
    end
    start = 1'b0;
    wait_idle("held");

    // Mid-frame reset: outputs clear immediately, no done pulse follows
    pattern = 8'hA5; start = 1'b1; clk_en = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_reset_x", 32'(x), 32'(exp_bit(8'hA5, 4)));
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outs", {28'd0, x, frame, busy, done}, 32'd0);
    chk("async_reset_state", 32'(dbg_state), 32'd0);
    repeat (3) begin
      tick();
      chk("reset_no_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    repeat (2) tick();
    chk("post_reset_idle", {30'd0, busy, frame}, 32'd0);
    run_tx(vecs[0], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
